// File: rtl/sim_axi_mem_lat.sv
// rtl/sim_axi_mem_lat.sv - AXI4 slave memory model with INCR bursts, byte strobes and fixed read latency
module sim_axi_mem_lat #(
    parameter int              ADDR_BITS = 32,
    parameter int              DATA_BITS = 64,
    parameter int              ID_BITS   = 5,
    parameter int              MEM_WORDS = 4096,
    parameter longint unsigned MEM_BASE  = 0,
    parameter int              READ_LAT  = 4,
    parameter int              RQ_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   axi_aw_valid,
    output logic                   axi_aw_ready,
    input  logic [ADDR_BITS-1:0]   axi_aw_addr,
    input  logic [ID_BITS-1:0]     axi_aw_id,
    input  logic [7:0]             axi_aw_len,

    input  logic                   axi_w_valid,
    output logic                   axi_w_ready,
    input  logic [DATA_BITS-1:0]   axi_w_data,
    input  logic [DATA_BITS/8-1:0] axi_w_strb,
    input  logic                   axi_w_last,

    output logic                   axi_b_valid,
    input  logic                   axi_b_ready,
    output logic [ID_BITS-1:0]     axi_b_id,
    output logic [1:0]             axi_b_resp,

    input  logic                   axi_ar_valid,
    output logic                   axi_ar_ready,
    input  logic [ADDR_BITS-1:0]   axi_ar_addr,
    input  logic [ID_BITS-1:0]     axi_ar_id,
    input  logic [7:0]             axi_ar_len,

    output logic                   axi_r_valid,
    input  logic                   axi_r_ready,
    output logic [ID_BITS-1:0]     axi_r_id,
    output logic [DATA_BITS-1:0]   axi_r_data,
    output logic [1:0]             axi_r_resp,
    output logic                   axi_r_last
);

    localparam int BYTES     = DATA_BITS / 8;
    localparam int SHIFT     = $clog2(BYTES);
    localparam int IDX_BITS  = $clog2(MEM_WORDS);
    localparam int RQ_BITS   = $clog2(RQ_DEPTH);
    localparam int TIME_BITS = 16;

    localparam logic [ADDR_BITS-1:0] BASE_A  = ADDR_BITS'(MEM_BASE);
    localparam logic [ADDR_BITS-1:0] WORDS_A = ADDR_BITS'(MEM_WORDS);
    localparam logic [ADDR_BITS-1:0] STEP_A  = ADDR_BITS'(BYTES);
    localparam logic [TIME_BITS-1:0] LAT_T   = TIME_BITS'(READ_LAT);
    localparam logic [RQ_BITS:0]     FULL_C  = (RQ_BITS+1)'(RQ_DEPTH);

    function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
        return (a >= BASE_A) && (((a - BASE_A) >> SHIFT) < WORDS_A);
    endfunction

    function automatic logic [IDX_BITS-1:0] addr_idx(input logic [ADDR_BITS-1:0] a);
        return IDX_BITS'((a - BASE_A) >> SHIFT);
    endfunction

    logic [DATA_BITS-1:0] mem [MEM_WORDS];

    logic unused_w_last;
    assign unused_w_last = axi_w_last;

    // Holds every ready low while reset is asserted, even though the FSMs already sit idle.
    logic running;
    always_ff @(posedge clock) begin
        if (reset) running <= 1'b0;
        else       running <= 1'b1;
    end

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t w_state, w_next;

    logic [ADDR_BITS-1:0] wr_addr;
    logic [ID_BITS-1:0]   wr_id;
    logic [7:0]           wr_len;
    logic [7:0]           wr_beat;
    logic                 wr_err;
    logic                 aw_hs, w_hs;

    assign aw_hs = axi_aw_valid && axi_aw_ready;
    assign w_hs  = axi_w_valid && axi_w_ready;

    always_ff @(posedge clock) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && (wr_beat == wr_len)) w_next = W_RESP;
            W_RESP:  if (axi_b_ready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        axi_aw_ready = 1'b0;
        axi_w_ready  = 1'b0;
        axi_b_valid  = 1'b0;
        case (w_state)
            W_IDLE:  axi_aw_ready = running;
            W_DATA:  axi_w_ready  = 1'b1;
            W_RESP:  axi_b_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr <= '0;
            wr_id   <= '0;
            wr_len  <= '0;
            wr_beat <= '0;
            wr_err  <= 1'b0;
        end else if (aw_hs) begin
            wr_addr <= axi_aw_addr;
            wr_id   <= axi_aw_id;
            wr_len  <= axi_aw_len;
            wr_beat <= '0;
            wr_err  <= 1'b0;
        end else if (w_hs) begin
            wr_addr <= wr_addr + STEP_A;
            wr_beat <= wr_beat + 8'd1;
            wr_err  <= wr_err | !addr_ok(wr_addr);
        end
    end

    assign axi_b_id   = wr_id;
    assign axi_b_resp = wr_err ? 2'd2 : 2'd0;

    always_ff @(posedge clock) begin
        if (!reset && w_hs && addr_ok(wr_addr)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi_w_strb[b]) mem[addr_idx(wr_addr)][b*8 +: 8] <= axi_w_data[b*8 +: 8];
            end
        end
    end

    logic [ADDR_BITS-1:0] rq_addr [RQ_DEPTH];
    logic [ID_BITS-1:0]   rq_id   [RQ_DEPTH];
    logic [7:0]           rq_len  [RQ_DEPTH];
    logic [TIME_BITS-1:0] rq_time [RQ_DEPTH];
    logic [RQ_BITS-1:0]   rq_wr, rq_rd, rq_nxt;
    logic [RQ_BITS:0]     rq_count;
    logic [TIME_BITS-1:0] cyc, now, head_diff, nxt_diff;
    logic                 push, pop, r_hs, head_ok, nxt_ok;

    assign axi_ar_ready = running && (rq_count != FULL_C);
    assign push   = axi_ar_valid && axi_ar_ready;
    assign r_hs   = axi_r_valid && axi_r_ready;
    assign pop    = r_hs && axi_r_last;
    assign rq_nxt = rq_rd + 1'b1;

    // cyc holds the index of the last edge; now is the edge about to happen.
    // Signed differences keep the readiness test valid across counter wrap.
    assign now       = cyc + 1'b1;
    assign head_diff = now - rq_time[rq_rd];
    assign nxt_diff  = now - rq_time[rq_nxt];
    assign head_ok   = (rq_count != '0) && !head_diff[TIME_BITS-1];
    assign nxt_ok    = (rq_count > (RQ_BITS+1)'(1)) && !nxt_diff[TIME_BITS-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc      <= '0;
            rq_wr    <= '0;
            rq_rd    <= '0;
            rq_count <= '0;
        end else begin
            cyc <= now;
            if (push) begin
                rq_addr[rq_wr] <= axi_ar_addr;
                rq_id[rq_wr]   <= axi_ar_id;
                rq_len[rq_wr]  <= axi_ar_len;
                rq_time[rq_wr] <= now + LAT_T;
                rq_wr          <= rq_wr + 1'b1;
            end
            if (pop) rq_rd <= rq_nxt;
            case ({push, pop})
                2'b10:   rq_count <= rq_count + 1'b1;
                2'b01:   rq_count <= rq_count - 1'b1;
                default: ;
            endcase
        end
    end

    logic [ADDR_BITS-1:0] rd_addr, ld_addr;
    logic [7:0]           rd_len, rd_beat, ld_len, ld_beat;
    logic [ID_BITS-1:0]   ld_id;
    logic                 ld;

    // On the last-beat handshake the entry behind the head is loaded directly, so bursts abut.
    always_comb begin
        ld      = 1'b0;
        ld_addr = rd_addr + STEP_A;
        ld_id   = axi_r_id;
        ld_len  = rd_len;
        ld_beat = rd_beat + 8'd1;
        if (r_hs && !axi_r_last) begin
            ld = 1'b1;
        end else if (pop && nxt_ok) begin
            ld      = 1'b1;
            ld_addr = rq_addr[rq_nxt];
            ld_id   = rq_id[rq_nxt];
            ld_len  = rq_len[rq_nxt];
            ld_beat = '0;
        end else if (!axi_r_valid && head_ok) begin
            ld      = 1'b1;
            ld_addr = rq_addr[rq_rd];
            ld_id   = rq_id[rq_rd];
            ld_len  = rq_len[rq_rd];
            ld_beat = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            axi_r_valid <= 1'b0;
            axi_r_id    <= '0;
            axi_r_data  <= '0;
            axi_r_resp  <= 2'd0;
            axi_r_last  <= 1'b0;
            rd_addr     <= '0;
            rd_len      <= '0;
            rd_beat     <= '0;
        end else if (ld) begin
            axi_r_valid <= 1'b1;
            axi_r_id    <= ld_id;
            axi_r_last  <= (ld_beat == ld_len);
            rd_addr     <= ld_addr;
            rd_len      <= ld_len;
            rd_beat     <= ld_beat;
            if (addr_ok(ld_addr)) begin
                axi_r_data <= mem[addr_idx(ld_addr)];
                axi_r_resp <= 2'd0;
            end else begin
                axi_r_data <= '0;
                axi_r_resp <= 2'd2;
            end
        end else if (r_hs) begin
            axi_r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sim_axi_mem_lat.sv
// tb/tb_sim_axi_mem_lat.sv - directed self-checking bench for sim_axi_mem_lat
module tb_sim_axi_mem_lat;

    logic        clock = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [4:0]  aw_id;
    logic [7:0]  aw_len;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [4:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [4:0]  ar_id;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [4:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;

    always #5 clock = ~clock;

    sim_axi_mem_lat dut (
        .clock(clock), .reset(reset),
        .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_addr(aw_addr),
        .axi_aw_id(aw_id), .axi_aw_len(aw_len),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_data(w_data),
        .axi_w_strb(w_strb), .axi_w_last(w_last),
        .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_id(b_id), .axi_b_resp(b_resp),
        .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_addr(ar_addr),
        .axi_ar_id(ar_id), .axi_ar_len(ar_len),
        .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_id(r_id),
        .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]  got_bresp;
    logic [4:0]  got_bid;
    logic [63:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic [4:0]  got_id   [16];
    logic        got_last [16];
    int          got_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic aw_write(input logic [31:0] addr, input logic [4:0] id, input int len,
                            input logic [63:0] d0, input logic [7:0] strb);
        int t;
        t = 0;
        while (!aw_ready && t < 50) begin tick(); t++; end
        check("aw_ready_wait", 64'(aw_ready), 64'd1);
        aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len[7:0];
        tick();
        aw_valid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            w_valid = 1'b1; w_data = d0 + 64'(n); w_strb = strb; w_last = (n == len);
            t = 0;
            while (!w_ready && t < 50) begin tick(); t++; end
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        t = 0;
        while (!b_valid && t < 50) begin tick(); t++; end
        check("b_valid_wait", 64'(b_valid), 64'd1);
        got_bresp = b_resp;
        got_bid   = b_id;
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("b_valid_drop", 64'(b_valid), 64'd0);
    endtask

    task automatic rd_issue(input logic [31:0] addr, input logic [4:0] id, input int len);
        int t;
        t = 0;
        while (!ar_ready && t < 50) begin tick(); t++; end
        check("ar_ready_wait", 64'(ar_ready), 64'd1);
        ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len[7:0];
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic rd_collect(input int nbeats);
        int t;
        got_n = 0;
        t = 0;
        r_ready = 1'b1;
        while (got_n < nbeats && t < 200) begin
            if (r_valid) begin
                got_data[got_n] = r_data;
                got_resp[got_n] = r_resp;
                got_id[got_n]   = r_id;
                got_last[got_n] = r_last;
                got_n++;
            end
            tick();
            t++;
        end
        r_ready = 1'b0;
        check("rd_beat_count", 64'(got_n), 64'(nbeats));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hs_ar, reasserted;
        int   ids [8];
        int   when [8];
        int   n;
        int   t;

        reset = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; r_ready = 0;
        repeat (3) tick();
        check("rst_aw_ready", 64'(aw_ready), 64'd0);
        check("rst_ar_ready", 64'(ar_ready), 64'd0);
        check("rst_w_ready",  64'(w_ready),  64'd0);
        check("rst_b_valid",  64'(b_valid),  64'd0);
        check("rst_r_valid",  64'(r_valid),  64'd0);
        check("rst_r_last",   64'(r_last),   64'd0);
        check("rst_r_data",   r_data,        64'd0);
        check("rst_b_resp",   64'(b_resp),   64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_aw_ready", 64'(aw_ready), 64'd1);
        check("post_rst_ar_ready", 64'(ar_ready), 64'd1);

        // Four-beat burst write then readback.
        aw_write(32'h40, 5'd5, 3, 64'h1000_0000_0000_00A0, 8'hFF);
        check("burst_b_resp", 64'(got_bresp), 64'd0);
        check("burst_b_id",   64'(got_bid),   64'd5);
        rd_issue(32'h40, 5'd7, 3);
        rd_collect(4);
        for (int i = 0; i < 4; i++) begin
            check("burst_r_data", got_data[i], 64'h1000_0000_0000_00A0 + 64'(i));
            check("burst_r_last", 64'(got_last[i]), 64'(i == 3));
            check("burst_r_id",   64'(got_id[i]),   64'd7);
            check("burst_r_resp", 64'(got_resp[i]), 64'd0);
        end
        check("burst_no_extra", 64'(r_valid), 64'd0);

        // Partial strobe merge.
        aw_write(32'h100, 5'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        aw_write(32'h100, 5'd2, 0, 64'h0000_0000_1122_3344, 8'h03);
        rd_issue(32'h100, 5'd3, 0);
        rd_collect(1);
        check("strb_merge", got_data[0], 64'hFFFF_FFFF_FFFF_3344);

        // First beat exactly READ_LAT edges after the AR handshake; outputs hold under backpressure.
        ar_valid = 1'b1; ar_addr = 32'h40; ar_id = 5'd9; ar_len = 8'd0;
        tick();
        ar_valid = 1'b0;
        check("lat_edge_k", 64'(r_valid), 64'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("lat_early", 64'(r_valid), 64'd0);
        end
        tick();
        check("lat_first_valid", 64'(r_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 64'(r_valid), 64'd1);
            check("hold_data",  r_data,       64'h1000_0000_0000_00A0);
            check("hold_id",    64'(r_id),    64'd9);
            check("hold_last",  64'(r_last),  64'd1);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("hold_release", 64'(r_valid), 64'd0);

        // Fill the request queue, then drain and expect issue order.
        for (int i = 1; i <= 4; i++) begin
            check("fill_ar_ready", 64'(ar_ready), 64'd1);
            ar_valid = 1'b1; ar_addr = 32'h40; ar_id = 5'(i); ar_len = 8'd0;
            tick();
        end
        ar_id = 5'd5;
        check("full_ar_ready", 64'(ar_ready), 64'd0);
        tick();
        tick();
        check("full_ar_ready_hold", 64'(ar_ready), 64'd0);
        r_ready = 1'b1;
        n = 0;
        reasserted = 1'b0;
        t = 0;
        while (t < 100 && n < 5) begin
            hs_ar = ar_valid && ar_ready;
            if (r_valid) begin
                ids[n]  = int'(r_id);
                when[n] = t;
                n++;
            end
            tick();
            if (hs_ar) begin
                ar_valid   = 1'b0;
                reasserted = 1'b1;
            end
            t++;
        end
        r_ready = 1'b0;
        ar_valid = 1'b0;
        check("drain_count", 64'(n), 64'd5);
        for (int i = 0; i < 5; i++) check("drain_order", 64'(ids[i]), 64'(i + 1));
        check("drain_ar_reassert", 64'(reasserted), 64'd1);
        check("drain_no_bubble", 64'(when[3] - when[0]), 64'd3);

        // Burst straddling the top of the array.
        aw_write(32'h7FF8, 5'd4, 1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        check("oor_b_resp", 64'(got_bresp), 64'd2);
        check("oor_b_id",   64'(got_bid),   64'd4);
        rd_issue(32'h7FF8, 5'd6, 1);
        rd_collect(2);
        check("oor_r_data0", got_data[0],       64'h0123_4567_89AB_CDEF);
        check("oor_r_resp0", 64'(got_resp[0]),  64'd0);
        check("oor_r_last0", 64'(got_last[0]),  64'd0);
        check("oor_r_data1", got_data[1],       64'd0);
        check("oor_r_resp1", 64'(got_resp[1]),  64'd2);
        check("oor_r_last1", 64'(got_last[1]),  64'd1);

        // Reset in the middle of a read burst.
        rd_issue(32'h40, 5'd2, 3);
        r_ready = 1'b1;
        t = 0;
        while (!r_valid && t < 50) begin tick(); t++; end
        check("mid_r_valid_wait", 64'(r_valid), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_r_valid",  64'(r_valid),  64'd0);
        check("mid_rst_ar_ready", 64'(ar_ready), 64'd0);
        check("mid_rst_aw_ready", 64'(aw_ready), 64'd0);
        check("mid_rst_r_data",   r_data,        64'd0);
        r_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("after_rst_ar_ready", 64'(ar_ready), 64'd1);
        check("after_rst_r_valid",  64'(r_valid),  64'd0);
        rd_issue(32'h40, 5'd8, 3);
        rd_collect(4);
        for (int i = 0; i < 4; i++) begin
            check("after_rst_data", got_data[i], 64'h1000_0000_0000_00A0 + 64'(i));
            check("after_rst_id",   64'(got_id[i]),   64'd8);
            check("after_rst_last", 64'(got_last[i]), 64'(i == 3));
        end
        check("after_rst_no_extra", 64'(r_valid), 64'd0);
        rd_issue(32'h100, 5'd10, 0);
        rd_collect(1);
        check("after_rst_strb_word", got_data[0], 64'hFFFF_FFFF_FFFF_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
